sra_sequencer: RTL and testbench

- Moore FSM that sequences the shared 8-bit datapath through a multi-cycle arithmetic shift right (Result = Input1 >>> ShAmt).
- Each SHIFT cycle drives the datapath's 1-bit SRA opcode.
- Drives the datapath's In, Bus2/5/7, AU1B3/AU1B4, LR and Opcode controls and signals completion with Done.
- Replaces the fixed controller for the SRA datapath so the shift count is programmable per operation.

---
 rtl/sra_sequencer.sv | 118 +++++++++++
 tb/tb_sra_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sra_sequencer.sv
// Moore controller that steps the shared 8-bit datapath through a programmable
// arithmetic shift right: LOAD, N one-bit SRA cycles, STORE, then a Done pulse.
module sra_sequencer #(
    parameter int unsigned CNT_W   = 3,
    parameter logic [3:0]  OP_SRA1 = 4'h6,
    parameter logic [3:0]  OP_PASS = 4'h0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [7:0]       ShAmt,
    output logic             In,
    output logic [1:0]       Bus2,
    output logic [1:0]       Bus5,
    output logic [1:0]       Bus7,
    output logic             AU1B3,
    output logic             AU1B4,
    output logic [4:0]       LR,
    output logic [3:0]       Opcode,
    output logic             Done,
    output logic             Busy,
    output logic [CNT_W-1:0] Count
);

    localparam int unsigned SH_W    = 8;
    localparam int unsigned MAX_CNT = (1 << CNT_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_load;

    // Shifting further than the counter can hold gives the same full sign fill,
    // so oversize requests saturate at the counter maximum.
    assign count_load = (ShAmt > SH_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : ShAmt[CNT_W-1:0];

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remaining-shift counter: loaded in LOAD, decremented once per SHIFT cycle
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else begin
            case (state)
                S_LOAD:  Count <= count_load;
                S_SHIFT: if (Count != '0) Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (count_load != '0) ? S_SHIFT : S_STORE;
            S_SHIFT: if (Count <= CNT_W'(1)) state_nxt = S_STORE;
            S_STORE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode, purely from the state register
    always_comb begin
        In     = 1'b0;
        Bus2   = 2'b00;
        Bus5   = 2'b00;
        Bus7   = 2'b00;
        AU1B3  = 1'b0;
        AU1B4  = 1'b0;
        LR     = 5'b00000;
        Opcode = OP_PASS;
        Done   = 1'b0;
        Busy   = 1'b0;
        case (state)
            S_LOAD: begin
                In   = 1'b1;
                LR   = 5'b00101;
                Busy = 1'b1;
            end
            S_SHIFT: begin
                Bus2   = 2'b01;
                Bus5   = 2'b01;
                AU1B3  = 1'b1;
                LR     = 5'b00100;
                Opcode = OP_SRA1;
                Busy   = 1'b1;
            end
            S_STORE: begin
                Bus7  = 2'b10;
                AU1B4 = 1'b1;
                LR    = 5'b10000;
                Busy  = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sra_sequencer.sv
// Directed bench for sra_sequencer with a small behavioural datapath model
// driven by the controller outputs to compute the shift result.
module tb_sra_sequencer;

    logic       clk;
    logic       Reset;
    logic       Start;
    logic [7:0] ShAmt;
    logic       In;
    logic [1:0] Bus2, Bus5, Bus7;
    logic       AU1B3, AU1B4;
    logic [4:0] LR;
    logic [3:0] Opcode;
    logic       Done, Busy;
    logic [2:0] Count;

    int n_cmp = 0;
    int n_err = 0;

    // {In,Bus2,Bus5,Bus7,AU1B3,AU1B4,LR,Opcode,Done,Busy}
    localparam logic [19:0] V_IDLE  = {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 4'h0, 1'b0, 1'b0};
    localparam logic [19:0] V_LOAD  = {1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00101, 4'h0, 1'b0, 1'b1};
    localparam logic [19:0] V_SHIFT = {1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 5'b00100, 4'h6, 1'b0, 1'b1};
    localparam logic [19:0] V_STORE = {1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 5'b10000, 4'h0, 1'b0, 1'b1};
    localparam logic [19:0] V_DONE  = {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 4'h0, 1'b1, 1'b0};

    logic [19:0] obs;
    assign obs = {In, Bus2, Bus5, Bus7, AU1B3, AU1B4, LR, Opcode, Done, Busy};

    sra_sequencer dut (
        .clk    (clk),
        .Reset  (Reset),
        .Start  (Start),
        .ShAmt  (ShAmt),
        .In     (In),
        .Bus2   (Bus2),
        .Bus5   (Bus5),
        .Bus7   (Bus7),
        .AU1B3  (AU1B3),
        .AU1B4  (AU1B4),
        .LR     (LR),
        .Opcode (Opcode),
        .Done   (Done),
        .Busy   (Busy),
        .Count  (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: accumulator, ALU and result register
    logic [7:0] input1, acc, res, alu;
    always_comb begin
        alu = acc;
        if (AU1B3 && Bus5 == 2'b01 && Opcode == 4'h6) alu = $signed(acc) >>> 1;
    end
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            acc <= 8'h00;
            res <= 8'h00;
        end else begin
            if (LR[2]) acc <= (In && Bus2 == 2'b00) ? input1 : ((Bus2 == 2'b01) ? alu : acc);
            if (LR[4] && AU1B4 && Bus7 == 2'b10) res <= alu;
        end
    end

    task automatic test_reset;
        Reset = 1'b0; Start = 1'b0; ShAmt = 8'd0; input1 = 8'h00;
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== V_IDLE || Count !== 3'd0) begin
            n_err++;
            $display("FAIL reset: ctl=%h cnt=%0d, expected ctl=%h cnt=0", obs, Count, V_IDLE);
        end
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== V_IDLE || Count !== 3'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: ctl=%h cnt=%0d, expected ctl=%h cnt=0", obs, Count, V_IDLE);
        end
    endtask

    task automatic test_sequences;
        logic [7:0] sh_t [5] = '{8'd3,  8'd0,  8'd200, 8'd1,  8'd8};
        logic [7:0] in_t [5] = '{8'hB4, 8'h5A, 8'h80,  8'h7F, 8'h40};
        int         n_t  [5] = '{3,     0,     7,      1,     7};
        logic [7:0] rs_t [5] = '{8'hF6, 8'h5A, 8'hFF,  8'h3F, 8'h00};
        logic [19:0] ev;
        logic [2:0]  ec;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            Start = 1'b1; ShAmt = sh_t[v]; input1 = in_t[v];
            for (int c = 1; c <= n_t[v] + 4; c++) begin
                @(negedge clk);
                Start = 1'b0;
                ec = 3'd0;
                if (c == 1) ev = V_LOAD;
                else if (c <= n_t[v] + 1) begin ev = V_SHIFT; ec = 3'(n_t[v] - (c - 2)); end
                else if (c == n_t[v] + 2) ev = V_STORE;
                else if (c == n_t[v] + 3) ev = V_DONE;
                else ev = V_IDLE;
                n_cmp++;
                if (obs !== ev || Count !== ec) begin
                    n_err++;
                    $display("FAIL seq%0d cyc%0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", v, c, obs, Count, ev, ec);
                end
            end
            n_cmp++;
            if (res !== rs_t[v]) begin
                n_err++;
                $display("FAIL seq%0d result: got %h, expected %h", v, res, rs_t[v]);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [19:0] ev;
        logic [2:0]  ec;
        @(negedge clk);
        Start = 1'b1; ShAmt = 8'd4; input1 = 8'hB4;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            Start = (c == 3 || c == 7);
            if (c >= 3) ShAmt = 8'd1;
            ec = 3'd0;
            if (c == 1) ev = V_LOAD;
            else if (c <= 5) begin ev = V_SHIFT; ec = 3'(4 - (c - 2)); end
            else if (c == 6) ev = V_STORE;
            else if (c == 7) ev = V_DONE;
            else ev = V_IDLE;
            n_cmp++;
            if (obs !== ev || Count !== ec) begin
                n_err++;
                $display("FAIL ignore_start cyc%0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", c, obs, Count, ev, ec);
            end
        end
        n_cmp++;
        if (res !== 8'hFB) begin
            n_err++;
            $display("FAIL ignore_start result: got %h, expected fb", res);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] ev;
        logic [2:0]  ec;
        @(negedge clk);
        Start = 1'b1; ShAmt = 8'd5; input1 = 8'h33;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== V_SHIFT || Count !== 3'd4) begin
            n_err++;
            $display("FAIL reset_mid pre: ctl=%h cnt=%0d, expected ctl=%h cnt=4", obs, Count, V_SHIFT);
        end
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== V_IDLE || Count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid async: ctl=%h cnt=%0d, expected ctl=%h cnt=0", obs, Count, V_IDLE);
        end
        @(negedge clk);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== V_IDLE) begin
                n_err++;
                $display("FAIL reset_mid no_done cyc%0d: ctl=%h, expected ctl=%h", c, obs, V_IDLE);
            end
        end
        Start = 1'b1; ShAmt = 8'd2; input1 = 8'hC8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            Start = 1'b0;
            ec = 3'd0;
            if (c == 1) ev = V_LOAD;
            else if (c <= 3) begin ev = V_SHIFT; ec = 3'(2 - (c - 2)); end
            else if (c == 4) ev = V_STORE;
            else if (c == 5) ev = V_DONE;
            else ev = V_IDLE;
            n_cmp++;
            if (obs !== ev || Count !== ec) begin
                n_err++;
                $display("FAIL reset_mid restart cyc%0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", c, obs, Count, ev, ec);
            end
        end
        n_cmp++;
        if (res !== 8'hF2) begin
            n_err++;
            $display("FAIL reset_mid result: got %h, expected f2", res);
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_ignore_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
